// File: rtl/fib_bcd_host_if.sv
// Bundles the system-side request/result signals and the fib handshake of fib_bcd_host.
// The host uses the slave modport; the system/fib side uses master.
interface fib_bcd_host_if #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 90,
  parameter int N_DIG = 28
);
  logic                 start;
  logic [N_IN-1:0]      n_in;
  logic                 busy;
  logic                 done;
  logic [N_OUT-1:0]     bin;
  logic [4*N_DIG-1:0]   bcd;
  logic                 fib_req;
  logic [N_IN-1:0]      fib_n;
  logic                 fib_ack;
  logic [N_OUT-1:0]     fib_result;

  modport slave (
    input  start, n_in, fib_ack, fib_result,
    output busy, done, bin, bcd, fib_req, fib_n
  );

  modport master (
    output start, n_in, fib_ack, fib_result,
    input  busy, done, bin, bcd, fib_req, fib_n
  );
endinterface

// File: rtl/fib_bcd_host.sv
// Host front end for the fib calculator: runs one four-phase req/ack transaction,
// then converts the binary result to packed BCD with a sequential double-dabble.
module fib_bcd_host #(
  parameter int N_IN  = 7,
  parameter int N_OUT = 90,
  parameter int N_DIG = 28
) (
  input  logic             clk,
  input  logic             rst,
  fib_bcd_host_if.slave    bus
);

  localparam int ITER_W = $clog2(N_OUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_RELEASE,
    S_CONV,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_nextState;

  logic [N_IN-1:0]      r_fibN;
  logic [N_OUT-1:0]     r_bin;
  logic [N_OUT-1:0]     r_binWork;
  logic [4*N_DIG-1:0]   r_bcd;
  logic [4*N_DIG-1:0]   r_bcdWork;
  logic [ITER_W-1:0]    r_iter;
  logic                 r_ackLow;

  logic                 w_lastIter;
  logic                 w_capture;
  logic [4*N_DIG-1:0]   w_bcdAdj;
  logic [4*N_DIG-1:0]   w_bcdNext;
  logic [N_OUT-1:0]     w_binNext;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_fibReq;

  assign w_lastIter = (r_iter == ITER_W'(N_OUT - 1));
  // An ack still high from the previous transaction must not be taken as this one's.
  assign w_capture  = bus.fib_ack && r_ackLow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_nextState = (bus.n_in == '0) ? S_CONV : S_REQ;
        end
      end
      S_REQ: begin
        if (!bus.fib_ack) begin
          w_nextState = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (w_capture) begin
          w_nextState = S_RELEASE;
        end
      end
      S_RELEASE: w_nextState = S_CONV;
      S_CONV: begin
        if (w_lastIter) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_fibReq = 1'b0;
    case (r_state)
      S_REQ, S_WAIT_ACK: begin
        w_busy   = 1'b1;
        w_fibReq = 1'b1;
      end
      S_RELEASE, S_CONV: w_busy = 1'b1;
      S_DONE:            w_done = 1'b1;
      default: ;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left.
  always_comb begin
    w_bcdAdj = r_bcdWork;
    for (int d = 0; d < N_DIG; d++) begin
      if (r_bcdWork[4*d +: 4] >= 4'd5) begin
        w_bcdAdj[4*d +: 4] = r_bcdWork[4*d +: 4] + 4'd3;
      end
    end
    {w_bcdNext, w_binNext} = {w_bcdAdj, r_binWork} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fibN    <= '0;
      r_bin     <= '0;
      r_binWork <= '0;
      r_bcd     <= '0;
      r_bcdWork <= '0;
      r_iter    <= '0;
      r_ackLow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_fibN <= bus.n_in;
            if (bus.n_in == '0) begin
              r_bin     <= '0;
              r_binWork <= '0;
              r_bcdWork <= '0;
              r_iter    <= '0;
            end else begin
              r_ackLow  <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (!bus.fib_ack) begin
            r_ackLow <= 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (w_capture) begin
            r_bin     <= bus.fib_result;
            r_binWork <= bus.fib_result;
          end
        end
        S_RELEASE: begin
          r_bcdWork <= '0;
          r_iter    <= '0;
        end
        S_CONV: begin
          r_bcdWork <= w_bcdNext;
          r_binWork <= w_binNext;
          r_iter    <= r_iter + 1'b1;
          if (w_lastIter) begin
            r_bcd <= w_bcdNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.fib_req = w_fibReq;
  assign bus.fib_n   = r_fibN;
  assign bus.bin     = r_bin;
  assign bus.bcd     = r_bcd;

endmodule

// File: tb/tb_fib_bcd_host.sv
// Directed bench for fib_bcd_host with a behavioural fib responder whose ack
// stays high after a transaction until the next request arrives.
module tb_fib_bcd_host;
  localparam int N_IN    = 7;
  localparam int N_OUT   = 90;
  localparam int N_DIG   = 28;
  localparam int FIB_LAT = 3;
  // fib_req is high for the model's FIB_LAT cycles plus its sample and capture cycles.
  localparam int REQ_CYC = FIB_LAT + 2;
  localparam int LAT_FIB = N_OUT + REQ_CYC + 3;
  localparam int LAT_N0  = N_OUT + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_bcd_host_if #(.N_IN(N_IN), .N_OUT(N_OUT), .N_DIG(N_DIG)) bus();

  fib_bcd_host #(.N_IN(N_IN), .N_OUT(N_OUT), .N_DIG(N_DIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum {M_IDLE, M_CALC, M_HOLD} mstate_t;
  mstate_t         mState;
  int              mCnt;
  logic [N_IN-1:0] mN;

  function automatic logic [N_OUT-1:0] fibOf(input logic [N_IN-1:0] n);
    logic [N_OUT-1:0] a;
    logic [N_OUT-1:0] b;
    logic [N_OUT-1:0] t;
    a = '0;
    b = 1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Fib responder: drops a stale ack when a new request is seen, computes, then holds ack.
  always @(posedge clk) begin
    if (rst) begin
      mState         <= M_IDLE;
      mCnt           <= 0;
      bus.fib_ack    <= 1'b0;
      bus.fib_result <= '0;
    end else begin
      case (mState)
        M_IDLE: begin
          if (bus.fib_req) begin
            bus.fib_ack <= 1'b0;
            mN          <= bus.fib_n;
            mCnt        <= 0;
            mState      <= M_CALC;
          end
        end
        M_CALC: begin
          if (mCnt == FIB_LAT - 1) begin
            bus.fib_ack    <= 1'b1;
            bus.fib_result <= fibOf(mN);
            mState         <= M_HOLD;
          end else begin
            mCnt <= mCnt + 1;
          end
        end
        M_HOLD: begin
          if (!bus.fib_req) begin
            mState <= M_IDLE;
          end
        end
        default: mState <= M_IDLE;
      endcase
    end
  end

  int vectorCount = 0;
  int missCount   = 0;

  int              lastCycles;
  int              lastReqHigh;
  bit              lastDoneSeen;
  logic            busyAt2;
  logic            reqAt2;
  logic [N_IN-1:0] fibNAt2;
  logic            busyAtDone;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Starts a transaction in the cycle after the call and follows it to the done cycle.
  // Cycle 1 is the start cycle; lastCycles is the inclusive count through the done cycle.
  task automatic applyStimulus(input logic [N_IN-1:0] n, input bit pokeBusy);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.n_in     = n;
    lastCycles   = 1;
    lastReqHigh  = 0;
    lastDoneSeen = 1'b0;
    busyAtDone   = 1'b1;
    for (int k = 0; k < 400 && !lastDoneSeen; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      lastCycles++;
      if (bus.fib_req) lastReqHigh++;
      if (lastCycles == 2) begin
        busyAt2 = bus.busy;
        reqAt2  = bus.fib_req;
        fibNAt2 = bus.fib_n;
      end
      if (bus.done) begin
        lastDoneSeen = 1'b1;
        busyAtDone   = bus.busy;
      end else if (pokeBusy && (lastCycles == 2 || lastCycles == 40)) begin
        bus.start = 1'b1;
        bus.n_in  = 7'd5;
      end
    end
  endtask

  initial begin
    bit sawDone;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.n_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_ctrl", {bus.busy, bus.done, bus.fib_req, bus.fib_n}, '0);
    checkOutput("reset_bin", bus.bin, '0);
    checkOutput("reset_bcd", bus.bcd, '0);

    applyStimulus(7'd10, 1'b0);
    checkOutput("n10_done", lastDoneSeen, 1);
    checkOutput("n10_req_next", reqAt2, 1);
    checkOutput("n10_fib_n", fibNAt2, 10);
    checkOutput("n10_busy", busyAt2, 1);
    checkOutput("n10_bin", bus.bin, 55);
    checkOutput("n10_bcd", bus.bcd, 'h55);
    checkOutput("n10_busy_at_done", busyAtDone, 0);
    checkOutput("n10_latency", lastCycles, LAT_FIB);
    @(posedge clk); #1;
    checkOutput("n10_done_pulse", {bus.done, bus.busy}, 0);

    applyStimulus(7'd90, 1'b0);
    checkOutput("n90_done", lastDoneSeen, 1);
    checkOutput("n90_bin", bus.bin, 90'd2880067194370816120);
    checkOutput("n90_bcd", bus.bcd, 112'h2880067194370816120);
    checkOutput("n90_latency", lastCycles, LAT_FIB);

    applyStimulus(7'd1, 1'b0);
    checkOutput("b2b_n1_bcd", bus.bcd, 'h1);
    applyStimulus(7'd2, 1'b0);
    checkOutput("b2b_n2_done", lastDoneSeen, 1);
    checkOutput("b2b_n2_bcd", bus.bcd, 'h1);
    checkOutput("b2b_n2_latency", lastCycles, LAT_FIB);
    applyStimulus(7'd4, 1'b0);
    checkOutput("b2b_n4_bin", bus.bin, 3);
    applyStimulus(7'd3, 1'b0);
    checkOutput("b2b_n3_bin", bus.bin, 2);
    checkOutput("b2b_n3_bcd", bus.bcd, 'h2);
    applyStimulus(7'd13, 1'b0);
    checkOutput("n13_bcd", bus.bcd, 'h233);

    applyStimulus(7'd0, 1'b0);
    checkOutput("n0_done", lastDoneSeen, 1);
    checkOutput("n0_no_req", lastReqHigh, 0);
    checkOutput("n0_bin", bus.bin, 0);
    checkOutput("n0_bcd", bus.bcd, 0);
    checkOutput("n0_latency", lastCycles, LAT_N0);

    applyStimulus(7'd7, 1'b1);
    checkOutput("busy_ign_done", lastDoneSeen, 1);
    checkOutput("busy_ign_bin", bus.bin, 13);
    checkOutput("busy_ign_bcd", bus.bcd, 'h13);
    checkOutput("busy_ign_fib_n", bus.fib_n, 7);
    checkOutput("busy_ign_latency", lastCycles, LAT_FIB);
    @(posedge clk); #1;
    checkOutput("busy_ign_idle", {bus.done, bus.busy}, 0);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n_in  = 7'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_ctrl", {bus.busy, bus.done, bus.fib_req, bus.fib_n}, '0);
    checkOutput("midrst_bin", bus.bin, '0);
    checkOutput("midrst_bcd", bus.bcd, '0);
    sawDone = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) sawDone = 1'b1;
    end
    checkOutput("midrst_stays_idle", sawDone, 0);

    applyStimulus(7'd12, 1'b0);
    checkOutput("n12_done", lastDoneSeen, 1);
    checkOutput("n12_bin", bus.bin, 144);
    checkOutput("n12_bcd", bus.bcd, 'h144);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/fib_bcd_host.md
Name: fib_bcd_host

Overview:
Host-side controller that sits directly upstream of the fib calculator and drives its req/n handshake. It accepts a single-cycle start from the system and runs one full four-phase transaction with fib. It then converts the returned binary result to packed BCD using sequential double-dabble and presents the value with a done pulse. It is the front end a display/UART stage reads decimal Fibonacci numbers from.

Parameters:
N_IN, 7, width of index n (must match fib N_IN)
N_OUT, 90, width of binary result (must match fib N_OUT)
N_DIG, 28, number of BCD digits; must satisfy 10^N_DIG > 2^N_OUT (28 for 90)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request to compute F(n_in); ignored while busy=1
n_in  in  N_IN  index, sampled on the cycle start is accepted
busy  out  1  high from accepted start until the cycle done pulses
done  out  1  one-cycle pulse: bin/bcd valid
bin  out  N_OUT  binary F(n), held until next accepted start
bcd  out  4*N_DIG  packed BCD of bin, digit 0 in bits [3:0], held until next accepted start
fib_req  out  1  to fib req
fib_n  out  N_IN  to fib n, held stable while fib_req=1
fib_ack  in  1  from fib ack
fib_result  in  N_OUT  from fib result

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, done=0, bin=0, bcd=0, fib_req=0, fib_n=0; internal shift regs, iteration counter and ack_low flag cleared. Reset wins over all other inputs. Reset mid-transaction drops fib_req immediately. The system resets fib in the same cycle.
- States: IDLE, REQ, WAIT_ACK, RELEASE, CONV, DONE.
- IDLE: on start=1, latch n_in into fib_n and set busy=1.
  - If n_in==0: bin=0 and go to CONV directly; no fib transaction (fib is undefined for n=0).
  - Else: fib_req=1, ack_low=0, go to REQ.
- REQ: fib_ack may still be high from the previous transaction, so it is ignored until it is seen low. When fib_ack==0, set ack_low=1 and go to WAIT_ACK.
- WAIT_ACK: on fib_ack==1, capture fib_result into bin and the shift register, set fib_req=0, go to RELEASE.
- RELEASE: fib leaves its handshake-fall state the cycle after it sees req low. Hold one cycle, then go to CONV.
  - fib_ack stays high after this point; this is legal and not an error.
- CONV (double-dabble): exactly N_OUT iterations, one per cycle, counter 0..N_OUT-1.
  - Each iteration: every BCD digit >=5 gets +3, then {bcd_work, bin_work} shift left by 1.
  - BCD work register is cleared on entry to CONV.
  - After the last iteration, bcd is loaded from the work register and the state goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE. A start in the following cycle is accepted.
- start while busy=1: ignored, with no effect on fib_n or the outputs.
- Latency, start to done:
  - n>=1: 1 (REQ entry) + fib latency + 1 (RELEASE) + N_OUT + 1 cycles.
  - n=0: N_OUT+2 cycles.
- No overflow handling is needed: F(127) < 2^90, and 10^28 > 2^90.
- bin/bcd change only on capture and at end of CONV. done never asserts without a completed conversion.

Test Plan:
- Reset, then start with n_in=10 -> fib_req rises the next cycle with fib_n=10. After fib ack: bin=55 and bcd=0x...0055, done pulses once, busy falls with done.
- n_in=90 -> bin=2880067194370816120 and bcd digits read "2880067194370816120" (19 digits, upper 9 digits zero). Start-to-done is N_OUT+fib latency+3 cycles.
- Back-to-back: n_in=1 then n_in=2 issued the cycle after done -> both give bcd=0x1. The second transaction must not capture the stale ack=1 left high by the first (ack_low gating).
- n_in=0 -> fib_req stays 0 throughout, bin=0, bcd=0, done pulses after N_OUT+2 cycles.
- start pulsed in REQ and in CONV with n_in=5 -> ignored; the running result (e.g. n=7 -> bcd 0x13) completes unchanged.
- rst asserted for one cycle midway through CONV -> next cycle all outputs 0, state IDLE, fib_req=0, no done pulse. A fresh start with n_in=12 then gives bcd=0x144.
